bcd_seven_seg_scan_driver: RTL and testbench
============================================

# bcd_seven_seg_scan_driver

Parametrised, time-multiplexed BCD-to-seven-segment display driver for a DIGITS-wide common-cathode display. It scans one digit per scan period, decodes that digit's BCD nibble to segments, and provides the blanking (BI) and lamp-test (LT) controls of the single-digit decoder. It adds leading-zero suppression, per-digit decimal points, and tear-free double-buffered updates applied only at frame boundaries. It sits between the datapath's BCD result registers and the board's segment/digit pins.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 1000, clock cycles each digit stays enabled; legal range >= 1. The prescaler width is $clog2(SCAN_DIV), minimum 1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bi_n  input  1  blanking input, active-low; highest priority.
- lt_n  input  1  lamp test, active-low.
- rbi_n  input  1  ripple-blank enable, active-low; 0 enables leading-zero suppression.
- load  input  1  single-cycle strobe; captures bcd_in and dp_in into the pending buffer.
- bcd_in  input  4*DIGITS  BCD digits; digit i is bits [4i+3:4i]; digit 0 is least significant.
- dp_in  input  DIGITS  per-digit decimal point.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- dp  output  1  decimal point for the enabled digit, registered.
- dig_en  output  DIGITS  one-hot digit enable, active-high, registered.
- frame_done  output  1  one-cycle pulse at each scan wrap.
- upd_ack  output  1  one-cycle pulse when pending data is transferred to the display buffer.
- err  output  1  registered; 1 while the enabled digit holds a code in the range 10..15.

## Operation
- **Prescaler**
  - cnt counts 0..SCAN_DIV-1. At terminal count (tc) it returns to 0 and the digit index idx advances.
  - idx runs 0..DIGITS-1 and wraps to 0.
- **Wrap and transfer**
  - A wrap is the cycle where tc=1 and idx=DIGITS-1. frame_done pulses on the edge following that cycle.
  - At a wrap with pend_valid=1: disp <= pend, pend_valid <= 0, and upd_ack pulses together with frame_done.
- **Loading**
  - load=1 captures {bcd_in, dp_in} into pend and sets pend_valid. Last load before the wrap wins.
  - If load coincides with a transfer, the transfer uses the old pend. The new data stays pending (pend_valid=1) for the next wrap.
- **Decode of disp digit[idx]**
  - 0..9 map to 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, gfedcba).
  - 10..15 map to 40 (dash) and set err=1.
- **Leading-zero suppression** (rbi_n=0)
  - A digit is blanked (seg=00) when it and every more-significant digit equal 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is still shown.
  - err is unaffected by suppression; codes 10..15 are non-zero and stop suppression.
- **Priority**
  - bi_n=0: seg=00, dp=0, dig_en=0, err=0. Scanning and buffering continue.
  - Otherwise lt_n=0: seg=7F and dp=1 on the scanned digit.
  - Otherwise normal decode.
- **Digit enable**: dig_en = 1<<idx whenever not blanked.

## Timing
- **Reset values**: cnt=0, idx=0, disp=0, pend=0, pend_valid=0. All outputs are 0, including seg, dp, dig_en, frame_done, upd_ack and err.
- **Output latency**: outputs are registered from the current {idx, disp, controls} with 1-cycle latency. The first edge after rst falls gives dig_en=0001 and seg=3F, since disp holds zeros.
- **Control latency**: a change on bi_n, lt_n or rbi_n is visible on the outputs 1 cycle later.
- **Dwell**: each digit is enabled for exactly SCAN_DIV cycles. A frame lasts DIGITS*SCAN_DIV cycles.
- **SCAN_DIV=1**: idx advances every cycle, and a wrap occurs every DIGITS cycles.
- **DIGITS=1**: every tc is a wrap.
- **Reset mid-operation**: all state returns to reset values immediately (asynchronously). A pending load is discarded and no upd_ack is issued.
- **Display stability**: disp never changes except at a wrap, so a displayed frame never mixes old and new digits.

## Test plan
- **Reset**: DIGITS=4, SCAN_DIV=4. Assert rst mid-scan -> all outputs 0 immediately. After release -> dig_en sequence 0001, 0010, 0100, 1000, each held 4 cycles, seg=3F throughout; frame_done pulses every 16 cycles.
- **Load and transfer**: load bcd_in=16'h1234, dp_in=4'b0100 at cycle 5 -> disp unchanged until the wrap. Then upd_ack and frame_done pulse together, and the next frame shows seg 66, 4F, 5B, 06 on digits 0..3, with dp=1 only on digit 2.
- **Leading-zero suppression**: disp=16'h0005 with rbi_n=0 -> digits 3..1 give seg=00 and digit 0 gives seg=6D. disp=16'h0000 -> only digit 0 shows 3F. With rbi_n=1 -> all digits show 3F.
- **Blanking and lamp test**: bi_n=0 with lt_n=0 -> seg=00, dig_en=0, and frame_done continues every 16 cycles. Then bi_n=1 with lt_n=0 -> seg=7F and dp=1 on every scanned digit.
- **Invalid code**: digit 2 = 4'hB -> while dig_en=0100, seg=40 and err=1; err=0 on the other digits.
- **Load collision**: load A, then load B coinciding with the wrap cycle -> A is displayed with upd_ack. B is held (pend_valid=1) and displayed at the following wrap with a second upd_ack.

Source files
------------

// File: rtl/bcd_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seven_seg_scan_driver
// Description : Multiplexed BCD to 7-segment driver, one digit per scan
//               period. Double-buffered display with frame-aligned updates.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seven_seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bi_n,
    input  logic                  lt_n,
    input  logic                  rbi_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done,
    output logic                  upd_ack,
    output logic                  err
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       c_seg_off  = 7'h00;
    localparam logic [6:0]       c_seg_all  = 7'h7F;
    localparam logic [6:0]       c_seg_dash = 7'h40;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_disp_bcd;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_bcd;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_valid;

    logic                w_tc;
    logic                w_wrap;
    logic                w_xfer;
    logic [3:0]          w_cur_bcd;
    logic                w_cur_dp;
    logic                w_cur_lz;
    logic [DIGITS-1:0]   w_lz;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;
    logic [DIGITS-1:0]   w_en_nxt;
    logic                w_err_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = c_seg_dash;
        endcase
        return s;
    endfunction

    assign w_tc   = (r_cnt == c_cnt_last);
    assign w_wrap = w_tc && (r_idx == c_idx_last);
    assign w_xfer = w_wrap && r_pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A load in the transfer cycle still wins pend; the transfer takes the old copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_disp_bcd <= r_pend_bcd;
                r_disp_dp  <= r_pend_dp;
            end
            if (load) begin
                r_pend_bcd   <= bcd_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // w_lz[i]: digit i and all more-significant digits are zero; digit 0 exempt.
    always_comb begin
        logic v_run;
        w_lz  = '0;
        v_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_run   = v_run & (r_disp_bcd[4*i +: 4] == 4'd0);
            w_lz[i] = v_run;
        end
    end

    always_comb begin
        w_cur_bcd = 4'd0;
        w_cur_dp  = 1'b0;
        w_cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_bcd = r_disp_bcd[4*i +: 4];
                w_cur_dp  = r_disp_dp[i];
                w_cur_lz  = w_lz[i];
            end
        end
    end

    always_comb begin
        w_seg_nxt = c_seg_off;
        w_dp_nxt  = 1'b0;
        w_en_nxt  = '0;
        w_err_nxt = 1'b0;
        if (bi_n) begin
            w_en_nxt  = DIGITS'(1) << r_idx;
            w_err_nxt = (w_cur_bcd > 4'd9);
            if (!lt_n) begin
                w_seg_nxt = c_seg_all;
                w_dp_nxt  = 1'b1;
            end else begin
                w_seg_nxt = (!rbi_n && w_cur_lz) ? c_seg_off : f_decode(w_cur_bcd);
                w_dp_nxt  = w_cur_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= c_seg_off;
            dp         <= 1'b0;
            dig_en     <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            seg        <= w_seg_nxt;
            dp         <= w_dp_nxt;
            dig_en     <= w_en_nxt;
            err        <= w_err_nxt;
            frame_done <= w_wrap;
            upd_ack    <= w_xfer;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seven_seg_scan_driver
// Description : Directed frame-by-frame bench, DIGITS=4, SCAN_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        bi_n, lt_n, rbi_n, load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        frame_done, upd_ack, err;

    int n_cmp = 0;
    int n_err = 0;

    bcd_seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .bi_n(bi_n), .lt_n(lt_n), .rbi_n(rbi_n),
        .load(load), .bcd_in(bcd_in), .dp_in(dp_in), .seg(seg), .dp(dp),
        .dig_en(dig_en), .frame_done(frame_done), .upd_ack(upd_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " seg"},    seg,        0);
        check({tag, " dp"},     dp,         0);
        check({tag, " dig_en"}, dig_en,     0);
        check({tag, " err"},    err,        0);
        check({tag, " fd"},     frame_done, 0);
        check({tag, " ack"},    upd_ack,    0);
    endtask

    // Entered on the negedge right after a frame boundary; checks 16 cycles.
    // s = {seg3, seg2, seg1, seg0}; loads are driven at negedge k for one cycle.
    task automatic run_frame(input int fno, input logic [27:0] s, input logic [3:0] dps,
                             input logic [3:0] errs, input logic blank, input logic upd_end,
                             input int ld_k, input logic [15:0] ld_bcd, input logic [3:0] ld_dp,
                             input int ld2_k, input logic [15:0] ld2_bcd, input logic [3:0] ld2_dp);
        for (int k = 0; k < 16; k++) begin
            int d;
            logic [3:0] e_en;
            @(negedge clk);
            d    = k / 4;
            e_en = blank ? 4'b0000 : (4'b0001 << d);
            check($sformatf("f%0d.%0d dig_en", fno, k), dig_en, e_en);
            check($sformatf("f%0d.%0d seg", fno, k), seg, s[d*7 +: 7]);
            check($sformatf("f%0d.%0d dp", fno, k), dp, dps[d]);
            check($sformatf("f%0d.%0d err", fno, k), err, errs[d]);
            check($sformatf("f%0d.%0d frame_done", fno, k), frame_done, (k == 15));
            check($sformatf("f%0d.%0d upd_ack", fno, k), upd_ack, (k == 15) && upd_end);
            load = 1'b0;
            if (k == ld_k) begin
                load = 1'b1; bcd_in = ld_bcd; dp_in = ld_dp;
            end
            if (k == ld2_k) begin
                load = 1'b1; bcd_in = ld2_bcd; dp_in = ld2_dp;
            end
        end
    endtask

    initial begin
        rst = 1'b1; bi_n = 1'b1; lt_n = 1'b1; rbi_n = 1'b1; load = 1'b0;
        bcd_in = 16'h0; dp_in = 4'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_frame(1,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 4'b0000, 1'b0, 1'b1,
                  5, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
        run_frame(2,  {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b0000, 1'b0, 1'b1,
                  3, 16'h0005, 4'b0000, -1, 16'h0, 4'h0);
        rbi_n = 1'b0;
        run_frame(3,  {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0000, 4'b0000, 1'b0, 1'b1,
                  3, 16'h0000, 4'b1000, -1, 16'h0, 4'h0);
        run_frame(4,  {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b1000, 4'b0000, 1'b0, 1'b1,
                  3, 16'h0B00, 4'b0000, -1, 16'h0, 4'h0);
        rbi_n = 1'b1;
        run_frame(5,  {7'h3F, 7'h40, 7'h3F, 7'h3F}, 4'b0000, 4'b0100, 1'b0, 1'b0,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        rbi_n = 1'b0;
        run_frame(6,  {7'h00, 7'h40, 7'h3F, 7'h3F}, 4'b0000, 4'b0100, 1'b0, 1'b0,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        rbi_n = 1'b1; bi_n = 1'b0; lt_n = 1'b0;
        run_frame(7,  28'h0, 4'b0000, 4'b0000, 1'b1, 1'b1,
                  3, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
        bi_n = 1'b1;
        run_frame(8,  {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 4'b0000, 1'b0, 1'b1,
                  3, 16'h5678, 4'b0001, 14, 16'h9012, 4'b0010);
        lt_n = 1'b1;
        run_frame(9,  {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0001, 4'b0000, 1'b0, 1'b1,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame(10, {7'h6F, 7'h3F, 7'h06, 7'h5B}, 4'b0010, 4'b0000, 1'b0, 1'b0,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Asynchronous reset mid-scan with a pending load that must be dropped.
        repeat (2) @(negedge clk);
        load = 1'b1; bcd_in = 16'h9999; dp_in = 4'hF;
        @(posedge clk);
        #1 load = 1'b0;
        check("pre-reset dig_en", dig_en, 4'b0001);
        #1 rst = 1'b1;
        #1 check_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        run_frame(12, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 4'b0000, 1'b0, 1'b0,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
